// File: rtl/imem_responder.sv
// Instruction-memory responder: word-wide preload port in LOAD, fetch port with a
// one-deep registered response and back-pressure in RUN.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          MEM_DEPTH = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_ld_en,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_err,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [31:0] o_fetch_cnt
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        r_ld_err;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_mem_q;
  logic [31:0] r_mem [0:MEM_DEPTH-1];

  // Port 0 decodes the load address, port 1 the fetch address.
  logic [31:0]   w_addr [0:1];
  logic [31:0]   w_off  [0:1];
  logic          w_ok   [0:1];
  logic [AW-1:0] w_idx  [0:1];

  assign w_addr[0] = i_ld_addr;
  assign w_addr[1] = i_req_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      // The >= test keeps addresses below the base from wrapping into range.
      assign w_off[gi] = w_addr[gi] - BASE_ADDR;
      assign w_ok[gi]  = (w_addr[gi][1:0] == 2'b00) &&
                         (w_addr[gi] >= BASE_ADDR) &&
                         ((w_off[gi] >> 2) < 32'(MEM_DEPTH));
      assign w_idx[gi] = w_off[gi][AW+1:2];
    end
  endgenerate

  logic w_run;
  logic w_accept;
  logic w_consume;
  logic w_ld_wr;
  logic w_rd_en;

  assign w_run       = (r_state == ST_RUN);
  assign o_req_ready = w_run && (!r_rsp_valid || i_rsp_ready);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_consume   = r_rsp_valid && i_rsp_ready;
  assign w_ld_wr     = i_ld_en && !w_run && w_ok[0];
  assign w_rd_en     = w_accept && w_ok[1];

  // Memory has no reset so the program image survives a core reset.
  always_ff @(posedge i_clock) begin
    if (w_ld_wr) begin
      r_mem[w_idx[0]] <= i_ld_data;
    end
    if (w_rd_en) begin
      r_mem_q <= r_mem[w_idx[1]];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_LOAD;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ld_err    <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      if (i_start && !w_run) begin
        r_state <= ST_RUN;
      end
      if (i_ld_en && (w_run || !w_ok[0])) begin
        r_ld_err <= 1'b1;
      end
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= !w_ok[1];
      end else if (w_consume) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Read register only loads on a good accept, so gate it for error/idle cases.
  assign o_rsp_data  = (r_rsp_valid && !r_rsp_err) ? r_mem_q : 32'h0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_ld_err    = r_ld_err;
  assign o_fetch_cnt = r_fetch_cnt;

endmodule
